// File: rtl/cache_repl_pkg.sv
// cache_repl_pkg: shared constants, width helpers and index typedefs for the
// FIFO replacement controller.
//   DefaultNumSets / DefaultNumWays : default cache geometry
//   set_w() / way_w()               : index widths derived via clog2
//   set_idx_t / way_idx_t           : index types for the default geometry
package cache_repl_pkg;

  localparam int unsigned DefaultNumSets = 8;
  localparam int unsigned DefaultNumWays = 2;

  // Floors at 1 so a degenerate geometry still yields a legal vector width.
  function automatic int unsigned set_w(input int unsigned num_sets);
    return (num_sets < 2) ? 1 : $clog2(num_sets);
  endfunction

  function automatic int unsigned way_w(input int unsigned num_ways);
    return (num_ways < 2) ? 1 : $clog2(num_ways);
  endfunction

  localparam int unsigned DefaultSetW = set_w(DefaultNumSets);
  localparam int unsigned DefaultWayW = way_w(DefaultNumWays);

  typedef logic [DefaultSetW-1:0] set_idx_t;
  typedef logic [DefaultWayW-1:0] way_idx_t;

endpackage

// File: rtl/cache_fifo_repl_if.sv
// cache_fifo_repl_if: request/response bundle for the FIFO replacement controller.
//   lookup_*  : lookup request (set, hit flag)
//   fill_*    : fill commit (set, way)
//   inval_*   : invalidate (set, way)
//   victim_*  : registered victim response
// Optional (CACHE_FIFO_REPL_LOCK_EN): lock_mask request input, victim_none response.
// Modports: master = requester side, slave = controller side.
interface cache_fifo_repl_if #(
  parameter int unsigned NUM_SETS = 8,
  parameter int unsigned NUM_WAYS = 2
) ();
  localparam int unsigned SetW = cache_repl_pkg::set_w(NUM_SETS);
  localparam int unsigned WayW = cache_repl_pkg::way_w(NUM_WAYS);

  logic            lookup_valid;
  logic [SetW-1:0] lookup_set;
  logic            lookup_hit;
  logic            fill_valid;
  logic [SetW-1:0] fill_set;
  logic [WayW-1:0] fill_way;
  logic            inval_valid;
  logic [SetW-1:0] inval_set;
  logic [WayW-1:0] inval_way;
  logic            victim_valid;
  logic [WayW-1:0] victim_way;
`ifdef CACHE_FIFO_REPL_LOCK_EN
  logic [NUM_WAYS-1:0] lock_mask;
  logic                victim_none;

  modport master (
    output lookup_valid, lookup_set, lookup_hit,
    output fill_valid, fill_set, fill_way,
    output inval_valid, inval_set, inval_way,
    output lock_mask,
    input  victim_valid, victim_way, victim_none
  );

  modport slave (
    input  lookup_valid, lookup_set, lookup_hit,
    input  fill_valid, fill_set, fill_way,
    input  inval_valid, inval_set, inval_way,
    input  lock_mask,
    output victim_valid, victim_way, victim_none
  );
`else
  modport master (
    output lookup_valid, lookup_set, lookup_hit,
    output fill_valid, fill_set, fill_way,
    output inval_valid, inval_set, inval_way,
    input  victim_valid, victim_way
  );

  modport slave (
    input  lookup_valid, lookup_set, lookup_hit,
    input  fill_valid, fill_set, fill_way,
    input  inval_valid, inval_set, inval_way,
    output victim_valid, victim_way
  );
`endif
endinterface

// File: rtl/cache_fifo_repl_pick.sv
// cache_fifo_repl_pick: combinational victim picker for one set.
//   valid_i     : per-way valid mask
//   ptr_i       : oldest-way pointer
//   lock_mask_i : ways excluded from replacement (CACHE_FIFO_REPL_LOCK_EN only)
//   way_o       : chosen victim way (0 when none)
//   none_o      : no eligible way exists
// Lowest-index invalid eligible way wins; otherwise the first eligible way at or
// above ptr_i, wrapping.
module cache_fifo_repl_pick
  import cache_repl_pkg::*;
#(
  parameter int unsigned NUM_WAYS = DefaultNumWays
) (
  input  logic [NUM_WAYS-1:0]         valid_i,
  input  logic [way_w(NUM_WAYS)-1:0]  ptr_i,
`ifdef CACHE_FIFO_REPL_LOCK_EN
  input  logic [NUM_WAYS-1:0]         lock_mask_i,
`endif
  output logic [way_w(NUM_WAYS)-1:0]  way_o,
  output logic                        none_o
);
  localparam int unsigned WayW = way_w(NUM_WAYS);

  logic [NUM_WAYS-1:0] eligible;
  logic [NUM_WAYS-1:0] cand;
  logic [WayW-1:0]     idx;
  logic                found;

  always_comb begin
`ifdef CACHE_FIFO_REPL_LOCK_EN
    eligible = ~lock_mask_i;
`else
    eligible = '1;
`endif
    cand   = ~valid_i & eligible;
    way_o  = '0;
    none_o = 1'b0;
    found  = 1'b0;
    idx    = '0;
    if (|cand) begin
      for (int unsigned i = 0; i < NUM_WAYS; i++) begin
        if (!found && cand[i]) begin
          way_o = WayW'(i);
          found = 1'b1;
        end
      end
    end else begin
      // NUM_WAYS is a power of two, so WayW-bit addition wraps modulo NUM_WAYS.
      for (int unsigned i = 0; i < NUM_WAYS; i++) begin
        idx = ptr_i + WayW'(i);
        if (!found && eligible[idx]) begin
          way_o = idx;
          found = 1'b1;
        end
      end
      none_o = ~found;
    end
  end

endmodule

// File: rtl/cache_fifo_repl.sv
// cache_fifo_repl: FIFO replacement controller for an N-way set-associative cache.
//   clk   : clock, rising edge
//   reset : synchronous, active-high; overrides all requests
//   bus   : cache_fifo_repl_if slave (lookup, fill, invalidate, victim response)
// Holds per-set valid masks and oldest-way pointers. A miss lookup returns a
// registered victim one cycle later, chosen from the state as updated by the
// same cycle's fill/invalidate.
// Optional feature macro: CACHE_FIFO_REPL_LOCK_EN (global way lock mask, victim_none).
module cache_fifo_repl
  import cache_repl_pkg::*;
#(
  parameter int unsigned NUM_SETS = DefaultNumSets,
  parameter int unsigned NUM_WAYS = DefaultNumWays
) (
  input  logic              clk,
  input  logic              reset,
  cache_fifo_repl_if.slave  bus
);
  localparam int unsigned WayW = way_w(NUM_WAYS);

  logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0] valid_d [NUM_SETS];
  logic [WayW-1:0]     ptr_q   [NUM_SETS];
  logic [WayW-1:0]     ptr_d   [NUM_SETS];

  logic            victim_valid_q, victim_valid_d;
  logic [WayW-1:0] victim_way_q, victim_way_d;
  logic            miss;
  logic [WayW-1:0] pick_way;
  logic            pick_none;
`ifdef CACHE_FIFO_REPL_LOCK_EN
  logic            victim_none_q, victim_none_d;
`endif

  // Invalidate is applied after fill so it wins on a same-set/same-way collision,
  // while the pointer advance (decided against ptr_q) still takes effect.
  always_comb begin
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (bus.fill_valid) begin
      valid_d[bus.fill_set][bus.fill_way] = 1'b1;
      if (bus.fill_way == ptr_q[bus.fill_set]) begin
        ptr_d[bus.fill_set] = ptr_q[bus.fill_set] + 1'b1;
      end
    end
    if (bus.inval_valid) begin
      valid_d[bus.inval_set][bus.inval_way] = 1'b0;
    end
  end

  // Picker sees next-state values so a same-cycle fill is never re-chosen.
  cache_fifo_repl_pick #(
    .NUM_WAYS (NUM_WAYS)
  ) u_pick (
    .valid_i     (valid_d[bus.lookup_set]),
    .ptr_i       (ptr_d[bus.lookup_set]),
`ifdef CACHE_FIFO_REPL_LOCK_EN
    .lock_mask_i (bus.lock_mask),
`endif
    .way_o       (pick_way),
    .none_o      (pick_none)
  );

  always_comb begin
    miss         = bus.lookup_valid & ~bus.lookup_hit;
    victim_way_d = miss ? pick_way : victim_way_q;
`ifdef CACHE_FIFO_REPL_LOCK_EN
    victim_valid_d = miss;
    victim_none_d  = miss & pick_none;
`else
    // Every way is eligible here, so pick_none is never set.
    victim_valid_d = miss & ~pick_none;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        ptr_q[s]   <= '0;
      end
      victim_valid_q <= 1'b0;
      victim_way_q   <= '0;
`ifdef CACHE_FIFO_REPL_LOCK_EN
      victim_none_q  <= 1'b0;
`endif
    end else begin
      for (int unsigned s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= valid_d[s];
        ptr_q[s]   <= ptr_d[s];
      end
      victim_valid_q <= victim_valid_d;
      victim_way_q   <= victim_way_d;
`ifdef CACHE_FIFO_REPL_LOCK_EN
      victim_none_q  <= victim_none_d;
`endif
    end
  end

  assign bus.victim_valid = victim_valid_q;
  assign bus.victim_way   = victim_way_q;
`ifdef CACHE_FIFO_REPL_LOCK_EN
  assign bus.victim_none  = victim_none_q;
`endif

endmodule
